// File: rtl/dump_buffer_pkg.sv
// Shared constants and types for the correlator dump capture path.
package dump_buffer_pkg;

    // Accumulator / output word / epoch width used when no override is given.
    localparam int ACC_WIDTH_DEFAULT = 16;

    // Each captured dump streams out as this many words.
    localparam int WORD_COUNT = 7;

    // Word index (out_sel) values, in streaming order.
    localparam logic [2:0] SEL_EPOCH = 3'd0;
    localparam logic [2:0] SEL_IE    = 3'd1;
    localparam logic [2:0] SEL_IP    = 3'd2;
    localparam logic [2:0] SEL_IL    = 3'd3;
    localparam logic [2:0] SEL_QE    = 3'd4;
    localparam logic [2:0] SEL_QP    = 3'd5;
    localparam logic [2:0] SEL_QL    = 3'd6;

    // Read side: nothing to offer, or streaming the head entry.
    typedef enum logic {
        RD_EMPTY  = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_t;

    // Word index after an accepted word: wraps to the epoch word after QL.
    function automatic logic [2:0] next_idx(input logic [2:0] idx);
        return (idx == SEL_QL) ? SEL_EPOCH : idx + 3'd1;
    endfunction

endpackage

// File: rtl/dump_fifo.sv
// Register-array FIFO holding whole dump entries; the head is read
// combinationally so the word mux downstream sees it without latency.
module dump_fifo #(
    parameter int WIDTH = 112,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    count_reg;
    logic             push_ok;
    logic             pop_ok;

    // A push into a full FIFO or a pop from an empty one is ignored.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    assign full    = (count_reg == LW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign level   = count_reg;
    assign rd_data = mem[rd_ptr_reg];

    // Entry storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + LW'(1);
            end else if (pop_ok && !push_ok) begin
                count_reg <= count_reg - LW'(1);
            end
        end
    end

endmodule

// File: rtl/dump_buffer.sv
// Snapshots the six correlator accumulators plus an epoch tag on every
// dump and streams each snapshot out as seven words over valid/ready.
module dump_buffer
    import dump_buffer_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEFAULT,
    parameter int DEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       dump,
    input  logic [ACC_WIDTH-1:0]       i_early,
    input  logic [ACC_WIDTH-1:0]       i_prompt,
    input  logic [ACC_WIDTH-1:0]       i_late,
    input  logic [ACC_WIDTH-1:0]       q_early,
    input  logic [ACC_WIDTH-1:0]       q_prompt,
    input  logic [ACC_WIDTH-1:0]       q_late,
    output logic [ACC_WIDTH-1:0]       out_data,
    output logic [2:0]                 out_sel,
    output logic                       out_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    input  logic                       overflow_clear
);

    localparam int W      = ACC_WIDTH;
    localparam int ENTRY_W = WORD_COUNT * W;

    logic [W-1:0]       epoch_reg;
    logic [2:0]         idx_reg;
    logic               overflow_reg;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               handshake;
    rd_state_t          rd_state;
    logic [W-1:0]       word_arr [8];

    // Epoch occupies the top word so word k sits at slice (6-k).
    assign wr_entry = {epoch_reg, i_early, i_prompt, i_late, q_early, q_prompt, q_late};

    // Full is sampled before the edge, so a dump is dropped even when the
    // head's last word leaves in the same cycle.
    assign push      = dump & ~fifo_full;
    assign handshake = out_valid & out_ready;
    assign pop       = handshake & (idx_reg == SEL_QL);
    assign rd_state  = fifo_empty ? RD_EMPTY : RD_STREAM;
    assign overflow  = overflow_reg;

    dump_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wr_data (wr_entry),
        .rd_data (head_entry),
        .level   (level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Split the head entry into words; index 7 never selects real data.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_words
            if (gi < WORD_COUNT) begin : g_real
                assign word_arr[gi] = head_entry[(WORD_COUNT-1-gi)*W +: W];
            end else begin : g_pad
                assign word_arr[gi] = '0;
            end
        end
    endgenerate

    // Output word mux; everything reads zero while nothing is buffered.
    always_comb begin
        out_valid = 1'b0;
        out_sel   = SEL_EPOCH;
        out_last  = 1'b0;
        out_data  = '0;
        case (rd_state)
            RD_STREAM: begin
                out_valid = 1'b1;
                out_sel   = idx_reg;
                out_last  = (idx_reg == SEL_QL);
                out_data  = word_arr[idx_reg];
            end
            default: begin
            end
        endcase
    end

    // Epoch counts every dump, dropped or not; stored value is pre-increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            epoch_reg <= '0;
        end else if (dump) begin
            epoch_reg <= epoch_reg + W'(1);
        end
    end

    // Word index advances on each accepted word and wraps when the entry pops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_reg <= SEL_EPOCH;
        end else if (handshake) begin
            idx_reg <= next_idx(idx_reg);
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_reg <= 1'b0;
        end else if (dump && fifo_full) begin
            overflow_reg <= 1'b1;
        end else if (overflow_clear) begin
            overflow_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dump_buffer.sv
// Directed bench for dump_buffer with a queue-based reference model.
module tb_dump_buffer;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int LW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          dump = 1'b0;
    logic          out_ready = 1'b0;
    logic          overflow_clear = 1'b0;
    logic [W-1:0]  ie = '0, ip = '0, il = '0, qe = '0, qp = '0, ql = '0;
    logic [W-1:0]  out_data;
    logic [2:0]    out_sel;
    logic          out_last;
    logic          out_valid;
    logic [LW-1:0] level;
    logic          overflow;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    dump_buffer #(.ACC_WIDTH(W), .DEPTH(D)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .dump           (dump),
        .i_early        (ie),
        .i_prompt       (ip),
        .i_late         (il),
        .q_early        (qe),
        .q_prompt       (qp),
        .q_late         (ql),
        .out_data       (out_data),
        .out_sel        (out_sel),
        .out_last       (out_last),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .level          (level),
        .overflow       (overflow),
        .overflow_clear (overflow_clear)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Entry word k: 0 epoch, 1 IE ... 6 QL.
    typedef logic [6:0][W-1:0] ent_t;
    ent_t         mq[$];
    int           m_idx   = 0;
    logic [W-1:0] m_epoch = '0;
    logic         m_ovf   = 1'b0;

    always @(negedge reset_n) begin
        mq.delete();
        m_idx   = 0;
        m_epoch = '0;
        m_ovf   = 1'b0;
    end

    always @(posedge clk) begin
        bit   was_full;
        ent_t e;
        if (reset_n) begin
            was_full = (mq.size() == D);
            if (mq.size() != 0 && out_ready) begin
                if (m_idx == 6) begin
                    void'(mq.pop_front());
                    m_idx = 0;
                end else begin
                    m_idx++;
                end
            end
            if (dump) begin
                if (!was_full) begin
                    e[0] = m_epoch; e[1] = ie; e[2] = ip; e[3] = il;
                    e[4] = qe;      e[5] = qp; e[6] = ql;
                    mq.push_back(e);
                end
                m_epoch = m_epoch + 1'b1;
            end
            if (dump && was_full) m_ovf = 1'b1;
            else if (overflow_clear) m_ovf = 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit v;
        v = (mq.size() != 0);
        chk("out_valid", out_valid, v);
        chk("level", level, mq.size());
        chk("overflow", overflow, m_ovf);
        chk("out_sel", out_sel, v ? m_idx : 0);
        chk("out_last", out_last, v && (m_idx == 6));
        if (v) chk("out_data", out_data, mq[0][m_idx]);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        dump = 1'b0; out_ready = 1'b0; overflow_clear = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic pulse_dump();
        dump = 1'b1;
        tick();
        dump = 1'b0;
    endtask

    logic [W-1:0] t1_exp [7];
    int           vcnt;

    initial begin
        t1_exp = '{16'h0000, 16'h0001, 16'hFFFE, 16'h0003, 16'hFFFC, 16'h0005, 16'hFFFA};

        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_level", level, 0);
        chk("rst_data", out_data, 0);
        tick();

        // Single dump, consumer always ready
        ie = 16'h0001; ip = 16'hFFFE; il = 16'h0003;
        qe = 16'hFFFC; qp = 16'h0005; ql = 16'hFFFA;
        out_ready = 1'b1;
        pulse_dump();
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("t1_data", out_data, t1_exp[k]);
            chk("t1_sel", out_sel, k);
            chk("t1_last", out_last, k == 6);
            tick();
        end
        @(negedge clk);
        chk("t1_valid_drop", out_valid, 0);

        // Five spaced dumps with consumer stalled: one dropped
        do_reset();
        out_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            ie = W'(n + 16'h10); qp = W'(16'h8000 + n);
            pulse_dump();
            repeat (99) tick();
        end
        @(negedge clk);
        chk("t2_level", level, 4);
        chk("t2_overflow", overflow, 1);
        tick();
        out_ready = 1'b1;
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            chk("t2_epoch", out_data, e);
            chk("t2_sel", out_sel, 0);
            repeat (7) tick();
        end
        @(negedge clk);
        chk("t2_drained", out_valid, 0);
        tick();
        pulse_dump();
        @(negedge clk);
        chk("t2_next_epoch", out_data, 5);
        repeat (8) tick();

        // Ready toggling: every word held while stalled, 14 cycles total
        do_reset();
        ie = 16'h1111; ip = 16'h2222; il = 16'h3333;
        qe = 16'h4444; qp = 16'h5555; ql = 16'h6666;
        pulse_dump();
        vcnt = 0;
        for (int c = 0; c < 20; c++) begin
            out_ready = c[0];
            @(negedge clk);
            if (out_valid) vcnt++;
            tick();
        end
        chk("t3_cycles", vcnt, 14);

        // Full buffer, last word popped in the same cycle as a dump
        do_reset();
        out_ready = 1'b0;
        for (int n = 0; n < 4; n++) begin
            ie = W'(16'hA0 + n);
            pulse_dump();
            tick();
        end
        @(negedge clk);
        chk("t4_full", level, 4);
        tick();
        out_ready = 1'b1;
        repeat (6) tick();
        dump = 1'b1;
        @(negedge clk);
        chk("t4_at_last", out_sel, 6);
        tick();
        dump = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("t4_level", level, 3);
        chk("t4_overflow", overflow, 1);
        chk("t4_head_epoch", out_data, 1);
        tick();

        // overflow_clear alone, then together with a drop
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        @(negedge clk);
        chk("t5_cleared", overflow, 0);
        tick();
        pulse_dump();
        @(negedge clk);
        chk("t5_refull", level, 4);
        tick();
        dump = 1'b1;
        overflow_clear = 1'b1;
        tick();
        dump = 1'b0;
        overflow_clear = 1'b0;
        @(negedge clk);
        chk("t5_set_wins", overflow, 1);
        tick();

        // Asynchronous reset in mid-stream
        do_reset();
        out_ready = 1'b0;
        pulse_dump();
        tick();
        pulse_dump();
        out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0;
        @(negedge clk);
        chk("t6_pre_level", level, 2);
        chk("t6_pre_sel", out_sel, 3);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_data", out_data, 0);
        chk("t6_rst_sel", out_sel, 0);
        chk("t6_rst_last", out_last, 0);
        chk("t6_rst_level", level, 0);
        chk("t6_rst_ovf", overflow, 0);
        tick();
        reset_n = 1'b1;
        tick();
        ie = 16'h7777;
        pulse_dump();
        @(negedge clk);
        chk("t6_epoch0", out_data, 0);
        chk("t6_valid", out_valid, 1);
        out_ready = 1'b1;
        repeat (9) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
